// File: rtl/pyramid_scan_ctrl_pkg.sv
// Shared definitions for the Viola-Jones pyramid scan sequencer.
// Holds the default geometry constants and the scan FSM state type.
package pyramid_scan_ctrl_pkg;

    localparam int WINDOW_SIZE_DEF    = 24;
    localparam int PYRAMID_LEVELS_DEF = 12;
    localparam int COORD_W_DEF        = 16;
    localparam int LVL_W_DEF          = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRESCAN,
        LOAD,
        SCAN,
        FINISH
    } scan_state_t;

endpackage

// File: rtl/pyramid_scan_ctrl_raster.sv
// Row/col raster counter for one pyramid level; limits are latched on load.
// End detection uses col + WINDOW_SIZE >= lim so it cannot underflow on small levels.
module pyramid_scan_ctrl_raster #(
    parameter int COORD_W     = 16,
    parameter int WINDOW_SIZE = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] lim_w_in,
    input  logic [COORD_W-1:0] lim_h_in,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               at_level_end
);

    localparam logic [COORD_W:0] WS = (COORD_W+1)'(WINDOW_SIZE);

    logic [COORD_W-1:0] lim_w;
    logic [COORD_W-1:0] lim_h;
    logic               at_row_end;
    logic               at_last_row;

    assign at_row_end   = ({1'b0, col} + WS) >= {1'b0, lim_w};
    assign at_last_row  = ({1'b0, row} + WS) >= {1'b0, lim_h};
    assign at_level_end = at_row_end && at_last_row;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lim_w <= '0;
            lim_h <= '0;
            row   <= '0;
            col   <= '0;
        end else if (load) begin
            lim_w <= lim_w_in;
            lim_h <= lim_h_in;
            row   <= '0;
            col   <= '0;
        end else if (advance) begin
            if (!at_row_end) begin
                col <= col + COORD_W'(1);
            end else if (!at_last_row) begin
                col <= '0;
                row <= row + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pyramid_scan_ctrl.sv
// Scan-window sequencer: prescans level sizes, then issues one (level,row,col)
// request per legal window with valid/ready handshake and completion reporting.
module pyramid_scan_ctrl
    import pyramid_scan_ctrl_pkg::*;
#(
    parameter int LEVELS      = PYRAMID_LEVELS_DEF,
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int LVL_W       = LVL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic [LVL_W-1:0]   cfg_level,
    input  logic [COORD_W-1:0] cfg_width,
    input  logic [COORD_W-1:0] cfg_height,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [LVL_W-1:0]   win_level,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_last,
    output logic               busy,
    output logic               done,
    output logic [31:0]        win_count
);

    localparam logic [LVL_W-1:0]   LAST_LVL = LVL_W'(LEVELS - 1);
    localparam logic [COORD_W-1:0] WS       = COORD_W'(WINDOW_SIZE);

    scan_state_t      state, state_n;
    logic [LVL_W-1:0] cfg_level_n;
    logic [LVL_W-1:0] win_level_n;
    logic [LVL_W-1:0] last_fit, last_fit_n;
    logic [31:0]      win_count_n;
    logic             win_valid_n;
    logic             cnt_load;
    logic             cnt_advance;
    logic             at_level_end;
    logic             lvl_fits;
    logic             xfer;

    assign lvl_fits = (cfg_width >= WS) && (cfg_height >= WS);
    assign xfer     = win_valid && win_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    // Highest fitting level is known from the prescan, so last is purely combinational.
    assign win_last = win_valid && at_level_end && (win_level == last_fit);

    pyramid_scan_ctrl_raster #(
        .COORD_W     (COORD_W),
        .WINDOW_SIZE (WINDOW_SIZE)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .load         (cnt_load),
        .advance      (cnt_advance),
        .lim_w_in     (cfg_width),
        .lim_h_in     (cfg_height),
        .row          (win_row),
        .col          (win_col),
        .at_level_end (at_level_end)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cfg_level <= '0;
            win_level <= '0;
            last_fit  <= '0;
            win_count <= '0;
            win_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cfg_level <= cfg_level_n;
            win_level <= win_level_n;
            last_fit  <= last_fit_n;
            win_count <= win_count_n;
            win_valid <= win_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        cfg_level_n = cfg_level;
        win_level_n = win_level;
        last_fit_n  = last_fit;
        win_count_n = win_count;
        win_valid_n = win_valid;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    win_count_n = '0;
                    cfg_level_n = '0;
                    last_fit_n  = '0;
                    state_n     = PRESCAN;
                end
            end
            PRESCAN: begin
                if (lvl_fits) last_fit_n = cfg_level;
                if (cfg_level == LAST_LVL) begin
                    cfg_level_n = '0;
                    state_n     = LOAD;
                end else begin
                    cfg_level_n = cfg_level + LVL_W'(1);
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                if (!lvl_fits) begin
                    if (cfg_level == LAST_LVL) state_n = FINISH;
                    else cfg_level_n = cfg_level + LVL_W'(1);
                end else begin
                    win_level_n = cfg_level;
                    win_valid_n = 1'b1;
                    state_n     = SCAN;
                end
            end
            SCAN: begin
                if (xfer) begin
                    win_count_n = win_count + 32'd1;
                    cnt_advance = 1'b1;
                    if (at_level_end) begin
                        win_valid_n = 1'b0;
                        if (cfg_level == LAST_LVL) begin
                            state_n = FINISH;
                        end else begin
                            cfg_level_n = cfg_level + LVL_W'(1);
                            state_n     = LOAD;
                        end
                    end
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pyramid_scan_ctrl.sv
// Directed scoreboard bench for pyramid_scan_ctrl with a 3-level pyramid.
module tb_pyramid_scan_ctrl;

    localparam int LV = 3;

    typedef struct packed {
        logic [3:0]  lvl;
        logic [15:0] row;
        logic [15:0] col;
        logic        last;
    } req_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        win_ready = 1'b0;
    logic [3:0]  cfg_level;
    logic [15:0] cfg_width, cfg_height;
    logic        win_valid, win_last, busy, done;
    logic [3:0]  win_level;
    logic [15:0] win_row, win_col;
    logic [31:0] win_count;

    logic [15:0] w_tab [LV];
    logic [15:0] h_tab [LV];

    req_t exp_q[$];
    int   exp_count = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    always_comb begin
        cfg_width  = '0;
        cfg_height = '0;
        if (cfg_level < 4'(LV)) begin
            cfg_width  = w_tab[cfg_level[1:0]];
            cfg_height = h_tab[cfg_level[1:0]];
        end
    end

    pyramid_scan_ctrl #(
        .LEVELS(LV), .WINDOW_SIZE(24), .COORD_W(16), .LVL_W(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cfg_level  (cfg_level),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_level  (win_level),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last),
        .busy       (busy),
        .done       (done),
        .win_count  (win_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int w0, input int h0, input int w1, input int h1,
                           input int w2, input int h2);
        w_tab[0] = 16'(w0); h_tab[0] = 16'(h0);
        w_tab[1] = 16'(w1); h_tab[1] = 16'(h1);
        w_tab[2] = 16'(w2); h_tab[2] = 16'(h2);
    endtask

    task automatic build_model();
        int   lf;
        int   w, h;
        req_t e;
        lf = -1;
        exp_q.delete();
        for (int l = 0; l < LV; l++)
            if (w_tab[l] >= 16'd24 && h_tab[l] >= 16'd24) lf = l;
        for (int l = 0; l < LV; l++) begin
            w = int'(w_tab[l]);
            h = int'(h_tab[l]);
            if (w >= 24 && h >= 24) begin
                for (int r = 0; r <= h - 24; r++) begin
                    for (int c = 0; c <= w - 24; c++) begin
                        e.lvl  = 4'(l);
                        e.row  = 16'(r);
                        e.col  = 16'(c);
                        e.last = (l == lf) && (r == h - 24) && (c == w - 24);
                        exp_q.push_back(e);
                    end
                end
            end
        end
        exp_count = exp_q.size();
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: start re-pulsed mid-scan, 3: reset after 3 transfers
    task automatic run_scan(input int mode);
        int   xfers, dones, post, first_v;
        bit   repulsed, aborted, finished;
        req_t obs;
        xfers = 0; dones = 0; post = 0; first_v = -1;
        repulsed = 0; aborted = 0; finished = 0;
        build_model();
        win_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            start = 1'b0;
            if (mode == 2 && xfers == 3 && !repulsed) begin
                start = 1'b1;
                repulsed = 1;
            end
            if (mode == 3 && xfers == 3) begin
                reset = 1'b1;
                #1;
                check("rst_valid", 64'(win_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_count", 64'(win_count), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                @(negedge clock);
                check("rst_no_done", 64'(done), 64'd0);
                reset = 1'b0;
                aborted = 1;
                break;
            end
            win_ready = (mode == 1) ? 1'(cyc % 2) : 1'b1;
            if (win_valid) begin
                if (first_v < 0) first_v = cyc;
                obs = '{lvl: win_level, row: win_row, col: win_col, last: win_last};
                if (exp_q.size() == 0) begin
                    check("extra_req", 64'(obs), 64'h0);
                end else begin
                    check(win_ready ? "req_xfer" : "req_stall", 64'(obs), 64'(exp_q[0]));
                    if (win_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            if (done) dones++;
            if (dones > 0) begin
                post++;
                if (post == 3) begin
                    finished = 1;
                    break;
                end
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (!aborted) begin
            if (!finished) check("timeout", 64'd0, 64'd1);
            check("done_pulses", 64'(dones), 64'd1);
            check("left_in_queue", 64'(exp_q.size()), 64'd0);
            check("win_count", 64'(win_count), 64'(exp_count));
            check("busy_after", 64'(busy), 64'd0);
            check("valid_seen", 64'(first_v >= 0), 64'(exp_count > 0));
            if (mode == 0 && exp_count > 0) check("first_latency", 64'(first_v), 64'(2 + LV));
        end
    endtask

    initial begin
        set_cfg(26, 25, 24, 24, 10, 10);
        repeat (2) @(negedge clock);
        check("reset_state",
              64'({win_valid, win_last, busy, done, win_level, win_row, win_col, cfg_level}),
              64'd0);
        check("reset_count", 64'(win_count), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_scan(0);
        run_scan(1);

        set_cfg(26, 25, 20, 30, 25, 24);
        run_scan(0);

        set_cfg(10, 10, 10, 10, 10, 10);
        run_scan(0);

        set_cfg(26, 25, 24, 24, 10, 10);
        run_scan(2);
        run_scan(3);
        @(negedge clock);
        run_scan(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
